adder_arbiter: RTL and testbench

- Round-robin scheduler that shares one registered adder datapath (inputs en, a, b; output z; z = a+b, truncated to W bits) among N requesters.
- Accepts up to one operation per cycle and drives the adder inputs. Tracks which requester owns each in-flight operation and returns each result to its owner, tagged with the requester index.
- Sits between client blocks and the adder instance; it is the only driver of the adder inputs.

---
 rtl/adder_arbiter.sv | 108 ++++++++++
 tb/tb_adder_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared registered adder: accepts one op/cycle, result returns tagged ADD_LAT+2 cycles after accept.
// hold blocks new grants only; in-flight ops always complete and responses have no backpressure.
module adder_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 16,
  localparam int IDW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  input  logic             hold,
  output logic [N-1:0]     gnt,
  output logic             add_en,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_z,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_data,
  output logic [CNT_W-1:0] ops_done,
  output logic             busy
);

  logic [IDW-1:0] ptr;
  logic           sel_vld;
  logic [IDW-1:0] sel_id;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  int             idx;

  logic [ADD_LAT:0] tag_vld;
  logic [IDW-1:0]   tag_id [ADD_LAT+1];

  // First requester at or after ptr, wrapping; only one grant per cycle.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    sel_a   = '0;
    sel_b   = '0;
    gnt     = '0;
    idx     = 0;
    if (!hold) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!sel_vld && req[idx]) begin
          sel_vld  = 1'b1;
          sel_id   = IDW'(idx);
          sel_a    = a_in[idx*W +: W];
          sel_b    = b_in[idx*W +: W];
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      add_a <= '0;
      add_b <= '0;
    end else if (sel_vld) begin
      ptr   <= (sel_id == IDW'(N - 1)) ? '0 : sel_id + 1'b1;
      add_a <= sel_a;
      add_b <= sel_b;
    end
  end

  // Tag stage j is valid in the cycle the op has spent j cycles inside the adder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld <= '0;
      for (int j = 0; j <= ADD_LAT; j++) begin
        tag_id[j] <= '0;
      end
    end else begin
      tag_vld   <= {tag_vld[ADD_LAT-1:0], sel_vld};
      tag_id[0] <= sel_id;
      for (int j = 1; j <= ADD_LAT; j++) begin
        tag_id[j] <= tag_id[j-1];
      end
    end
  end

  assign add_en = tag_vld[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      ops_done  <= '0;
    end else begin
      rsp_valid <= tag_vld[ADD_LAT];
      if (tag_vld[ADD_LAT]) begin
        rsp_id   <= tag_id[ADD_LAT];
        rsp_data <= add_z;
        ops_done <= ops_done + 1'b1;
      end
    end
  end

  assign busy = (|tag_vld) | rsp_valid;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: two instances (ADD_LAT=1 and 3) share stimulus, each with its own adder model and scoreboard.
module tb_adder_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int CNT_W = 16;

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [W-1:0] data;
  } exp_t;

  logic           clk     = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req     = '0;
  logic [N*W-1:0] a_in    = '0;
  logic [N*W-1:0] b_in    = '0;
  logic           hold    = 1'b0;

  logic [N-1:0]     gnt1, gnt3;
  logic             add_en1, add_en3;
  logic [W-1:0]     add_a1, add_b1, add_a3, add_b3, add_z1, add_z3;
  logic             rsp_valid1, rsp_valid3;
  logic [1:0]       rsp_id1, rsp_id3;
  logic [W-1:0]     rsp_data1, rsp_data3;
  logic [CNT_W-1:0] ops_done1, ops_done3;
  logic             busy1, busy3;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mptr = 0;
  exp_t q1[$];
  exp_t q3[$];

  logic [N-1:0] gseq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0]   iseq [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [W-1:0] dseq [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  adder_arbiter #(.N(N), .W(W), .ADD_LAT(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in), .hold(hold),
    .gnt(gnt1), .add_en(add_en1), .add_a(add_a1), .add_b(add_b1), .add_z(add_z1),
    .rsp_valid(rsp_valid1), .rsp_id(rsp_id1), .rsp_data(rsp_data1),
    .ops_done(ops_done1), .busy(busy1)
  );

  adder_arbiter #(.N(N), .W(W), .ADD_LAT(3), .CNT_W(CNT_W)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in), .hold(hold),
    .gnt(gnt3), .add_en(add_en3), .add_a(add_a3), .add_b(add_b3), .add_z(add_z3),
    .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
    .ops_done(ops_done3), .busy(busy3)
  );

  // Adder models: sample on enable, then a fixed-latency shift.
  logic [W-1:0] z3p [3];
  always @(posedge clk) begin
    if (add_en1) add_z1 <= add_a1 + add_b1;
    if (add_en3) z3p[0] <= add_a3 + add_b3;
    z3p[1] <= z3p[0];
    z3p[2] <= z3p[1];
  end
  assign add_z3 = z3p[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p, input logic h);
    if (h) return -1;
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  // Check the current cycle against the model, then advance to the next negedge.
  task automatic step();
    int           pick;
    logic [N-1:0] eg;
    logic         v;
    exp_t         e;
    #1;
    pick = rr_pick(req, mptr, hold);
    eg = '0;
    if (pick >= 0) eg[pick] = 1'b1;
    chk("gnt_l1", 32'(gnt1), 32'(eg));
    chk("gnt_l3", 32'(gnt3), 32'(eg));

    v = (q1.size() > 0) && (q1[0].due == cyc);
    chk("rsp_valid_l1", 32'(rsp_valid1), 32'(v));
    if (v) begin
      e = q1.pop_front();
      chk("rsp_id_l1", 32'(rsp_id1), 32'(e.id));
      chk("rsp_data_l1", 32'(rsp_data1), 32'(e.data));
    end
    v = (q3.size() > 0) && (q3[0].due == cyc);
    chk("rsp_valid_l3", 32'(rsp_valid3), 32'(v));
    if (v) begin
      e = q3.pop_front();
      chk("rsp_id_l3", 32'(rsp_id3), 32'(e.id));
      chk("rsp_data_l3", 32'(rsp_data3), 32'(e.data));
    end

    if (pick >= 0) begin
      e.id   = 2'(pick);
      e.data = a_in[pick*W +: W] + b_in[pick*W +: W];
      e.due  = cyc + 3;
      q1.push_back(e);
      e.due  = cyc + 5;
      q3.push_back(e);
      mptr = (pick + 1) % N;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    hold    = 1'b0;
    #1;
    chk("rst_add_en", 32'(add_en1), 0);
    chk("rst_add_a", 32'(add_a1), 0);
    chk("rst_add_b", 32'(add_b1), 0);
    chk("rst_rsp_valid", 32'(rsp_valid1), 0);
    chk("rst_rsp_id", 32'(rsp_id1), 0);
    chk("rst_rsp_data", 32'(rsp_data1), 0);
    chk("rst_ops_done", 32'(ops_done1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_busy_l3", 32'(busy3), 0);
    chk("rst_add_en_l3", 32'(add_en3), 0);
    q1.delete();
    q3.delete();
    mptr = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int           pick;
    int           created;
    int           accepted;
    logic [N-1:0] pend;

    #2;
    do_reset();

    // Single op from requester 0.
    set_op(0, 8'h12, 8'h34);
    req = 4'b0001;
    #1;
    chk("t1_gnt", 32'(gnt1), 32'h1);
    step();
    req = '0;
    chk("t1_add_en", 32'(add_en1), 1);
    chk("t1_add_a", 32'(add_a1), 32'h12);
    chk("t1_add_b", 32'(add_b1), 32'h34);
    chk("t1_busy", 32'(busy1), 1);
    step();
    step();
    chk("t1_rsp_valid", 32'(rsp_valid1), 1);
    chk("t1_rsp_id", 32'(rsp_id1), 0);
    chk("t1_rsp_data", 32'(rsp_data1), 32'h46);
    step();
    chk("t1_rsp_data_hold", 32'(rsp_data1), 32'h46);
    chk("t1_ops_done", 32'(ops_done1), 1);
    chk("t1_busy_idle", 32'(busy1), 0);

    // All four requesting: strict rotation, back-to-back responses.
    do_reset();
    a_in = {8'h40, 8'h30, 8'h20, 8'h10};
    b_in = {8'h04, 8'h03, 8'h02, 8'h01};
    for (int t = 0; t < 12; t++) begin
      req = (t < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (t < 8) chk("t2_gnt", 32'(gnt1), 32'(gseq[t]));
      if (t >= 3 && t < 11) begin
        chk("t2_rsp_valid", 32'(rsp_valid1), 1);
        chk("t2_rsp_id", 32'(rsp_id1), 32'(iseq[t-3]));
        chk("t2_rsp_data", 32'(rsp_data1), 32'(dseq[t-3]));
      end
      step();
    end
    chk("t2_ops_done", 32'(ops_done1), 8);
    chk("t2_busy", 32'(busy1), 0);

    // One requester every cycle, carry discarded.
    set_op(2, 8'hFF, 8'h01);
    for (int t = 0; t < 9; t++) begin
      req = (t < 6) ? 4'b0100 : 4'b0000;
      #1;
      if (t < 6) chk("t3_gnt", 32'(gnt1), 32'h4);
      if (t >= 3) begin
        chk("t3_rsp_valid", 32'(rsp_valid1), 1);
        chk("t3_rsp_id", 32'(rsp_id1), 2);
        chk("t3_rsp_data", 32'(rsp_data1), 0);
      end
      step();
    end

    // Two accepts, then hold while 1 and 3 request; ptr sits at 2.
    set_op(0, 8'h01, 8'h02);
    set_op(1, 8'h7F, 8'h01);
    req = 4'b0011;
    #1;
    chk("t4_gnt0", 32'(gnt1), 32'h1);
    step();
    req = 4'b0010;
    #1;
    chk("t4_gnt1", 32'(gnt1), 32'h2);
    step();
    set_op(1, 8'h05, 8'h06);
    set_op(3, 8'h0A, 8'h0B);
    hold = 1'b1;
    req  = 4'b1010;
    for (int t = 2; t < 8; t++) begin
      #1;
      chk("t4_gnt_hold", 32'(gnt1), 0);
      if (t == 2) chk("t4_busy", 32'(busy1), 1);
      if (t == 3) begin
        chk("t4_rsp_id_a", 32'(rsp_id1), 0);
        chk("t4_rsp_data_a", 32'(rsp_data1), 32'h03);
      end
      if (t == 4) begin
        chk("t4_rsp_id_b", 32'(rsp_id1), 1);
        chk("t4_rsp_data_b", 32'(rsp_data1), 32'h80);
      end
      if (t == 5) chk("t4_busy_drained", 32'(busy1), 0);
      step();
    end
    hold = 1'b0;
    #1;
    chk("t4_gnt_resume", 32'(gnt1), 32'h8);
    step();
    req = 4'b0010;
    #1;
    chk("t4_gnt_next", 32'(gnt1), 32'h2);
    step();
    req = '0;
    step();
    chk("t4_rsp_id_c", 32'(rsp_id1), 3);
    chk("t4_rsp_data_c", 32'(rsp_data1), 32'h15);
    step();
    chk("t4_rsp_id_d", 32'(rsp_id1), 1);
    chk("t4_rsp_data_d", 32'(rsp_data1), 32'h0B);
    step();

    // Reset right after an accept discards the op.
    set_op(0, 8'h21, 8'h22);
    req = 4'b0001;
    #1;
    chk("t5_gnt", 32'(gnt1), 32'h1);
    step();
    chk("t5_add_en_pre", 32'(add_en1), 1);
    do_reset();
    for (int t = 0; t < 8; t++) step();
    chk("t5_ops_done", 32'(ops_done1), 0);
    chk("t5_ops_done_l3", 32'(ops_done3), 0);

    // Random traffic: 64 accepts with requesters holding until granted.
    pend     = '0;
    created  = 0;
    accepted = 0;
    for (int c = 0; c < 2000 && accepted < 64; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && created < 64 && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_op(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
          created++;
        end
      end
      req  = pend;
      hold = ($urandom_range(0, 7) == 0);
      #1;
      pick = rr_pick(req, mptr, hold);
      if (pick >= 0) begin
        pend[pick] = 1'b0;
        accepted++;
      end
      step();
    end
    chk("t6_accepts", 32'(accepted), 64);
    hold = 1'b0;
    req  = '0;
    for (int t = 0; t < 8; t++) step();
    chk("t6_q_empty_l1", 32'(q1.size()), 0);
    chk("t6_q_empty_l3", 32'(q3.size()), 0);
    chk("t6_ops_done", 32'(ops_done1), 64);
    chk("t6_ops_done_l3", 32'(ops_done3), 64);
    chk("t6_busy", 32'(busy1), 0);
    chk("t6_busy_l3", 32'(busy3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
